// File: rtl/axi_exclusive_slave_if.sv
// AXI4 bundle shared by the core master port and the exclusive-capable slave.
// Fixed widths: 4-bit IDs, 32-bit addresses, 32-bit data.
interface axi_interface;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_exclusive_slave.sv
// Single-outstanding AXI4 slave in front of a word-wide local memory, with
// exclusive-access support for LR/SC and AMO sequences.
// Optional macro AXI_SLAVE_EXCLUSIVE_EN: one-entry reservation monitor. Without
// it every in-range exclusive access succeeds (single-master systems only).
//
// state      | meaning
// IDLE       | waiting for AR or AW/W; reads win simultaneous arrival
// WR_COLLECT | one of AW/W captured, waiting for the other
// MEM_READ   | memory read strobe held until mem_ack
// MEM_WRITE  | memory write strobe held until mem_ack
// R_RESP     | read response held until rready
// B_RESP     | write response held until bready
module axi_exclusive_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] SIZE_BYTES = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    axi_interface.slave s_axi,
    output logic        mem_request,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE, WR_COLLECT, MEM_READ, MEM_WRITE, R_RESP, B_RESP
    } state_t;

    state_t state, state_nxt;

    logic        arready_c, awready_c, wready_c;
    logic        have_aw, have_w;
    logic [29:0] aw_word_q;
    logic        aw_ok_q, aw_lock_q;
    logic [3:0]  aw_id_q, id_q;
    logic [29:0] word_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q, rdata_q;
    logic [1:0]  rresp_q, bresp_q;

    // Address decode: offset wraps for addresses below BASE_ADDR, so one compare covers both ends.
    logic [31:0] ar_off, aw_off;
    logic        ar_ok;
    assign ar_off = s_axi.araddr - BASE_ADDR;
    assign aw_off = s_axi.awaddr - BASE_ADDR;
    assign ar_ok  = ar_off < SIZE_BYTES;

    logic ar_hs, aw_hs, w_hs, wr_done;
    assign ar_hs   = s_axi.arvalid & arready_c;
    assign aw_hs   = s_axi.awvalid & awready_c;
    assign w_hs    = s_axi.wvalid & wready_c;
    assign wr_done = ((state == IDLE) & aw_hs & w_hs) | ((state == WR_COLLECT) & (aw_hs | w_hs));

    // The write decision uses whichever of AW/W is arriving this cycle, else the captured copy.
    logic [29:0] wr_word;
    logic        wr_ok, wr_lock, excl_ok, wr_to_mem;
    logic [3:0]  wr_id, wr_strb;
    logic [31:0] wr_data;
    assign wr_word = aw_hs ? aw_off[31:2] : aw_word_q;
    assign wr_ok   = aw_hs ? (aw_off < SIZE_BYTES) : aw_ok_q;
    assign wr_lock = aw_hs ? s_axi.awlock : aw_lock_q;
    assign wr_id   = aw_hs ? s_axi.awid : aw_id_q;
    assign wr_data = w_hs ? s_axi.wdata : wdata_q;
    assign wr_strb = w_hs ? s_axi.wstrb : be_q;

`ifdef AXI_SLAVE_EXCLUSIVE_EN
    logic        res_valid;
    logic [29:0] res_addr;
    assign excl_ok = res_valid & (res_addr == wr_word);
`else
    assign excl_ok = 1'b1;
`endif
    assign wr_to_mem = wr_ok & (~wr_lock | excl_ok);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ar_hs)                state_nxt = ar_ok ? MEM_READ : R_RESP;
                else if (wr_done)         state_nxt = wr_to_mem ? MEM_WRITE : B_RESP;
                else if (aw_hs | w_hs)    state_nxt = WR_COLLECT;
            end
            WR_COLLECT: if (wr_done)      state_nxt = wr_to_mem ? MEM_WRITE : B_RESP;
            MEM_READ:   if (mem_ack)      state_nxt = R_RESP;
            MEM_WRITE:  if (mem_ack)      state_nxt = B_RESP;
            R_RESP:     if (s_axi.rready) state_nxt = IDLE;
            B_RESP:     if (s_axi.bready) state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Ready/valid/strobe decode from state; readies are held low while reset is asserted.
    always_comb begin
        arready_c   = ~rst & (state == IDLE);
        awready_c   = ~rst & (((state == IDLE) & ~s_axi.arvalid) | ((state == WR_COLLECT) & ~have_aw));
        wready_c    = ~rst & (((state == IDLE) & ~s_axi.arvalid) | ((state == WR_COLLECT) & ~have_w));
        mem_request = (state == MEM_READ) | (state == MEM_WRITE);
    end

    // Request capture, response data and reservation tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            have_aw   <= 1'b0;
            have_w    <= 1'b0;
            aw_word_q <= '0;
            aw_ok_q   <= 1'b0;
            aw_lock_q <= 1'b0;
            aw_id_q   <= '0;
            id_q      <= '0;
            word_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= 4'hF;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            bresp_q   <= RESP_OKAY;
`ifdef AXI_SLAVE_EXCLUSIVE_EN
            res_valid <= 1'b0;
            res_addr  <= '0;
`endif
        end else begin
            if (ar_hs) begin
                id_q    <= s_axi.arid;
                word_q  <= ar_off[31:2];
                we_q    <= 1'b0;
                be_q    <= 4'hF;
                rdata_q <= '0;
                rresp_q <= !ar_ok ? RESP_DECERR : (s_axi.arlock ? RESP_EXOKAY : RESP_OKAY);
`ifdef AXI_SLAVE_EXCLUSIVE_EN
                if (ar_ok & s_axi.arlock) begin
                    res_valid <= 1'b1;
                    res_addr  <= ar_off[31:2];
                end
`endif
            end
            if (aw_hs) begin
                have_aw   <= 1'b1;
                aw_word_q <= aw_off[31:2];
                aw_ok_q   <= aw_off < SIZE_BYTES;
                aw_lock_q <= s_axi.awlock;
                aw_id_q   <= s_axi.awid;
            end
            if (w_hs) begin
                have_w  <= 1'b1;
                wdata_q <= s_axi.wdata;
                be_q    <= s_axi.wstrb;
            end
            if (wr_done) begin
                have_aw <= 1'b0;
                have_w  <= 1'b0;
                id_q    <= wr_id;
                word_q  <= wr_word;
                we_q    <= 1'b1;
                wdata_q <= wr_data;
                be_q    <= wr_strb;
                if (!wr_ok)                 bresp_q <= RESP_DECERR;
                else if (wr_lock & excl_ok) bresp_q <= RESP_EXOKAY;
                else                        bresp_q <= RESP_OKAY;
`ifdef AXI_SLAVE_EXCLUSIVE_EN
                if (wr_ok & (wr_lock | (wr_word == res_addr)))
                    res_valid <= 1'b0;
`endif
            end
            if ((state == MEM_READ) & mem_ack)
                rdata_q <= mem_rdata;
        end
    end

    assign s_axi.arready = arready_c;
    assign s_axi.awready = awready_c;
    assign s_axi.wready  = wready_c;
    assign s_axi.rvalid  = (state == R_RESP);
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rid     = id_q;
    assign s_axi.rlast   = 1'b1;
    assign s_axi.bvalid  = (state == B_RESP);
    assign s_axi.bresp   = bresp_q;
    assign s_axi.bid     = id_q;

    assign mem_we    = we_q;
    assign mem_addr  = word_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

    // Burst attributes and sub-word address bits carry no meaning for single-beat word accesses.
    logic unused_ok;
    assign unused_ok = &{1'b0, ar_off[1:0], aw_off[1:0], s_axi.arlen, s_axi.arsize,
                         s_axi.arburst, s_axi.awlen, s_axi.awsize, s_axi.awburst, s_axi.wlast};
endmodule
